// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants, state encoding and stage-control payload for the
// pipeline hazard sequencer.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 32;

  localparam logic            DEASSERT      = 1'b0;
  localparam logic [XLEN-1:0] WORD_DEASSERT = '0;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_MEM_WAIT = 1'b1
  } hz_state_e;

  // One bit per controlled stage, oldest-to-youngest order reversed (IF first).
  typedef struct packed {
    logic if_s;
    logic id_s;
    logic iex_s;
    logic lsu_s;
  } stage_ctl_t;

  localparam stage_ctl_t STAGE_NONE = '0;
  localparam stage_ctl_t STAGE_ALL  = '1;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline status inputs and stall/flush/redirect controls of the hazard sequencer.
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs1_re;
  logic             id_rs2_re;
  logic             id_valid;
  logic             iex_valid;
  logic [REG_W-1:0] iex_rd;
  logic             iex_mem_re;
  logic             iex_jump_valid;
  logic             lsu_req;
  logic             lsu_ack;
  logic             trap_req;
  logic [XLEN-1:0]  trap_pc;

  logic             ac2if_stall;
  logic             ac2id_stall;
  logic             ac2iex_stall;
  logic             ac2lsu_stall;
  logic             ac2if_flush;
  logic             ac2id_flush;
  logic             ac2iex_flush;
  logic             ac2lsu_flush;
  logic             ac_redirect_valid;
  logic [XLEN-1:0]  ac_redirect_pc;
  logic             ac_bus_err;
  logic [CNT_W-1:0] ac_stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_rs1_re, id_rs2_re, id_valid, iex_valid, iex_rd,
           iex_mem_re, iex_jump_valid, lsu_req, lsu_ack, trap_req, trap_pc,
    input  ac2if_stall, ac2id_stall, ac2iex_stall, ac2lsu_stall,
           ac2if_flush, ac2id_flush, ac2iex_flush, ac2lsu_flush,
           ac_redirect_valid, ac_redirect_pc, ac_bus_err, ac_stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_re, id_rs2_re, id_valid, iex_valid, iex_rd,
           iex_mem_re, iex_jump_valid, lsu_req, lsu_ack, trap_req, trap_pc,
    output ac2if_stall, ac2id_stall, ac2iex_stall, ac2lsu_stall,
           ac2if_flush, ac2id_flush, ac2iex_flush, ac2lsu_flush,
           ac_redirect_valid, ac_redirect_pc, ac_bus_err, ac_stall_cnt
  );

endinterface

// File: rtl/hazard_lu_detect.sv
// Combinational load-use compare between the load in IEX and the consumer in ID.
module hazard_lu_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic             iex_valid,
  input  logic             iex_mem_re,
  input  logic [REG_W-1:0] iex_rd,
  input  logic             id_valid,
  input  logic             id_rs1_re,
  input  logic             id_rs2_re,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  output logic             lu_c
);

  // x0 never carries a dependency.
  assign lu_c = iex_valid & iex_mem_re & (iex_rd != '0) & id_valid &
                ((id_rs1_re & (iex_rd == id_rs1)) | (id_rs2_re & (iex_rd == id_rs2)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, jump and
// trap flushes, data-bus wait freeze with timeout, and a stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 16
) (
  input  logic               clk,
  input  logic               rstn,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  hz_state_e        state, next_state;
  logic             trap_pend, trap_pend_nxt;
  logic [XLEN-1:0]  trap_pc_q, trap_pc_q_nxt;
  logic [TO_W-1:0]  to_cnt, to_cnt_nxt;
  logic [CNT_W-1:0] stall_cnt;

  stage_ctl_t       stall, flush;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             bus_err;
  logic             lu_c, trap_act_c, mem_busy_c;

  hazard_lu_detect u_lu (
    .iex_valid  (bus.iex_valid),
    .iex_mem_re (bus.iex_mem_re),
    .iex_rd     (bus.iex_rd),
    .id_valid   (bus.id_valid),
    .id_rs1_re  (bus.id_rs1_re),
    .id_rs2_re  (bus.id_rs2_re),
    .id_rs1     (bus.id_rs1),
    .id_rs2     (bus.id_rs2),
    .lu_c       (lu_c)
  );

  assign trap_act_c = bus.trap_req | trap_pend;
  assign mem_busy_c = bus.lsu_req & ~bus.lsu_ack;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= HZ_RUN;
      trap_pend <= 1'b0;
      trap_pc_q <= '0;
      to_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= next_state;
      trap_pend <= trap_pend_nxt;
      trap_pc_q <= trap_pc_q_nxt;
      to_cnt    <= to_cnt_nxt;
      if (stall.if_s) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Outputs are held low while reset is asserted, independent of inputs.
  always_comb begin
    next_state     = state;
    trap_pend_nxt  = trap_pend;
    trap_pc_q_nxt  = trap_pc_q;
    to_cnt_nxt     = to_cnt;
    stall          = STAGE_NONE;
    flush          = STAGE_NONE;
    redirect_valid = DEASSERT;
    redirect_pc    = WORD_DEASSERT;
    bus_err        = DEASSERT;
    if (rstn) begin
      unique case (state)
        HZ_RUN: begin
          if (trap_act_c) begin
            flush.if_s     = 1'b1;
            flush.id_s     = 1'b1;
            flush.iex_s    = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = trap_pend ? trap_pc_q : bus.trap_pc;
            trap_pend_nxt  = 1'b0;
          end
          // A jump squashes the dependent instruction, so no bubble is needed.
          if (bus.iex_jump_valid) begin
            flush.if_s = 1'b1;
            flush.id_s = 1'b1;
          end else if (lu_c && !trap_act_c) begin
            stall.if_s = 1'b1;
            stall.id_s = 1'b1;
            flush.id_s = 1'b1;
          end
          if (mem_busy_c) begin
            stall       = STAGE_ALL;
            flush.lsu_s = 1'b1;
            next_state  = HZ_MEM_WAIT;
          end
        end
        HZ_MEM_WAIT: begin
          if (bus.trap_req && !trap_pend) begin
            trap_pend_nxt = 1'b1;
            trap_pc_q_nxt = bus.trap_pc;
          end
          if (bus.lsu_ack) begin
            next_state = HZ_RUN;
            to_cnt_nxt = '0;
          end else if (to_cnt == TO_LAST) begin
            bus_err     = 1'b1;
            flush.lsu_s = 1'b1;
            next_state  = HZ_RUN;
            to_cnt_nxt  = '0;
          end else begin
            stall       = STAGE_ALL;
            flush.lsu_s = 1'b1;
            to_cnt_nxt  = to_cnt + TO_W'(1);
          end
        end
        default: next_state = HZ_RUN;
      endcase
    end
  end

  assign bus.ac2if_stall       = stall.if_s;
  assign bus.ac2id_stall       = stall.id_s;
  assign bus.ac2iex_stall      = stall.iex_s;
  assign bus.ac2lsu_stall      = stall.lsu_s;
  assign bus.ac2if_flush       = flush.if_s;
  assign bus.ac2id_flush       = flush.id_s;
  assign bus.ac2iex_flush      = flush.iex_s;
  assign bus.ac2lsu_flush      = flush.lsu_s;
  assign bus.ac_redirect_valid = redirect_valid;
  assign bus.ac_redirect_pc    = redirect_pc;
  assign bus.ac_bus_err        = bus_err;
  assign bus.ac_stall_cnt      = stall_cnt;

endmodule
